pim_bus_arbiter_2x1: RTL
========================

# pim_bus_arbiter_2x1

Round-robin arbiter sharing one N-bit result bus between two requesters (A, B) in the PIM controller. It grants whole bursts, delimited by `last`, with a valid/ready handshake on both sides. It drives the select of the shared 2:1 data multiplexer. A beat limit guards against a requester that never asserts `last`.

## Interface
- `bus_size`, 6, data width of each requester and of the output bus
- `MAX_BEATS`, 16, maximum beats per burst before forced release (≥1)
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-high reset
- `a_valid` / `b_valid` in 1 — requester beat valid (also serves as request)
- `a_data` / `b_data` in bus_size — requester beat data
- `a_last` / `b_last` in 1 — final beat of burst
- `a_ready` / `b_ready` out 1 — beat accepted when valid & ready
- `out_valid` out 1 — granted requester's valid
- `out_data` out bus_size — granted requester's data (combinational through mux)
- `out_last` out 1 — granted requester's last (forced 1 on overrun beat)
- `out_ready` in 1 — downstream accepts beat
- `sel` out 1 — registered mux select, 0 = A, 1 = B
- `busy` out 1 — high in any GRANT state
- `overrun_err` out 1 — sticky burst-overrun flag
- `err_clr` in 1 — synchronous clear of `overrun_err`

## Operation
- States: ARB_IDLE, ARB_GRANT_A, ARB_GRANT_B. `prio` register: 0 = A preferred, 1 = B preferred.
- IDLE: only A valid → GRANT_A; only B valid → GRANT_B; both valid → side given by `prio`; neither → stay.
- GRANT_x:
  - `x_ready = out_ready`; other requester's ready = 0.
  - `out_valid = x_valid`; `out_data` and `out_last` taken from x.
- Beat accepted: `x_valid & out_ready` in GRANT_x. The beat counter increments on each accepted beat.
- Burst end: accepted beat with `x_last`, or accepted beat that makes count == MAX_BEATS.
- On burst end:
  - `prio` flips to the other side.
  - Beat counter clears to 0.
  - Next state, evaluated with the new `prio` against the same-cycle valids: other side valid → GRANT_other (no bubble); else own side valid → GRANT_x; else IDLE.
- Overrun: count reaches MAX_BEATS without `x_last`.
  - `out_last` driven 1 on that beat.
  - `overrun_err` set.
  - Grant released as above.
- `x_valid` dropping mid-burst does not release the grant; the grant is held until burst end.
- `err_clr` and an overrun in the same cycle → `overrun_err` = 1 (set wins).
- `sel` follows state: GRANT_B → 1, GRANT_A → 0, IDLE → retains last value.
- Reset values:
  - state IDLE, `sel` 0, `prio` 0, count 0, `overrun_err` 0.
  - Hence `busy` 0, `out_valid` 0, `a_ready` / `b_ready` 0, `out_last` 0, `out_data` = `a_data`.

## Timing
- Arbitration latency is 1 cycle: valid first seen in IDLE at edge t; grant state and `sel` are valid after edge t, so the first beat can transfer in cycle t+1.
- Back-to-back bursts: switching to the other side costs zero idle cycles.
- Ready paths are combinational from `out_ready` and the registered state; there is no combinational path from `valid` to `ready`.
- Async `rst` mid-burst: all registers go to reset values immediately. The in-flight burst is abandoned; no beat is accepted while `rst` = 1.
- Beat counter width: `$clog2(MAX_BEATS+1)`. The counter never wraps because it clears at burst end.

## Structure
- Shared package `pim_arb_pkg`:
  - `typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_GRANT_A, ARB_GRANT_B}`
  - constants `SEL_A = 1'b0`, `SEL_B = 1'b1`
- Sub-module `arb_beat_counter`:
  - inputs: `inc`, `clr`
  - outputs: `count`, `at_max`
  - parameter: `MAX_BEATS`
- FSM, `prio` and `overrun_err` live in the top.
- Output data select is the N-bit 2:1 mux driven by `sel`.

## Test plan
- Reset, then A alone sends 3-beat burst (0x11, 0x12, 0x13 with last), `out_ready` = 1 → GRANT_A one cycle after valid; `out_data` 0x11..0x13; `sel` = 0; IDLE after beat 3.
- A and B both valid from reset, each 2-beat → A served first (`prio` 0), then B with no bubble; `sel` 0→1; `prio` ends 0.
- B in 2-beat burst, `out_ready` low for 3 cycles mid-burst → `b_ready` low for those cycles, beat held stable, `a_ready` 0 throughout, grant kept.
- `MAX_BEATS` = 4, A streams 6 beats without last → 4 beats accepted; `out_last` 1 on 4th; `overrun_err` 1; grant released; `err_clr` pulse → 0.
- Async `rst` asserted during beat 2 of a B burst → `busy`, `out_valid`, `b_ready`, `sel` all 0 immediately; after release, A request is granted normally.
- Both requesters continuously valid with 1-beat bursts → strict alternation A, B, A, B, one beat per cycle.

Source files
------------

// File: rtl/pim_arb_pkg.sv
// Shared types and constants for the PIM result-bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package pim_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT_A,
        ARB_GRANT_B
    } arb_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/arb_beat_counter.sv
// Counts accepted beats of the current burst and flags the beat that hits the limit.
// Latency: count updates one cycle after inc; at_max is combinational from the count.
// Backpressure: none; the owner only pulses inc on accepted beats.
module arb_beat_counter #(
    parameter int MAX_BEATS = 16,
    parameter int CW        = $clog2(MAX_BEATS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          at_max
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // High while the beat on the bus would be the MAX_BEATS-th of the burst.
    assign at_max = (count_q == CW'(MAX_BEATS - 1));
    assign count  = count_q;

endmodule

// File: rtl/pim_bus_arbiter_2x1.sv
// Round-robin burst arbiter sharing one result bus between requesters A and B.
// Latency: grant one cycle after valid is seen in idle; zero-bubble handover between sides.
// Backpressure: granted side's ready follows out_ready combinationally; the other side sees 0.
module pim_bus_arbiter_2x1
    import pim_arb_pkg::*;
#(
    parameter int bus_size  = 6,
    parameter int MAX_BEATS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    input  logic [bus_size-1:0] a_data,
    input  logic                a_last,
    output logic                a_ready,
    input  logic                b_valid,
    input  logic [bus_size-1:0] b_data,
    input  logic                b_last,
    output logic                b_ready,
    output logic                out_valid,
    output logic [bus_size-1:0] out_data,
    output logic                out_last,
    input  logic                out_ready,
    output logic                sel,
    output logic                busy,
    output logic                overrun_err,
    input  logic                err_clr
);

    localparam int CW = $clog2(MAX_BEATS + 1);

    arb_state_t state_q, state_d;
    logic       prio_q, prio_d;
    logic       sel_q, sel_d;
    logic       ovr_q, ovr_d;

    logic          accept;
    logic          cur_last;
    logic          burst_end;
    logic          overrun;
    logic          at_max;
    logic [CW-1:0] beat_cnt;

    arb_beat_counter #(
        .MAX_BEATS (MAX_BEATS),
        .CW        (CW)
    ) u_beat_counter (
        .clk    (clk),
        .rst    (rst),
        .inc    (accept),
        .clr    (burst_end),
        .count  (beat_cnt),
        .at_max (at_max)
    );

    // The raw count is kept for debug visibility; control only needs at_max.
    logic beat_cnt_unused;
    assign beat_cnt_unused = ^beat_cnt;

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        sel_d     = sel_q;
        ovr_d     = ovr_q;
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        accept    = 1'b0;
        cur_last  = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (a_valid && (!b_valid || prio_q == SEL_A)) begin
                    state_d = ARB_GRANT_A;
                end else if (b_valid) begin
                    state_d = ARB_GRANT_B;
                end
            end
            ARB_GRANT_A: begin
                a_ready   = out_ready;
                out_valid = a_valid;
                out_last  = a_last | at_max;
                cur_last  = a_last;
                accept    = a_valid & out_ready;
            end
            ARB_GRANT_B: begin
                b_ready   = out_ready;
                out_valid = b_valid;
                out_last  = b_last | at_max;
                cur_last  = b_last;
                accept    = b_valid & out_ready;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        burst_end = accept & (cur_last | at_max);
        overrun   = accept & at_max & ~cur_last;

        // Priority flips to the other side, which then gets first claim on the bus.
        if (burst_end) begin
            if (state_q == ARB_GRANT_A) begin
                prio_d = SEL_B;
                if (b_valid) begin
                    state_d = ARB_GRANT_B;
                end else if (a_valid) begin
                    state_d = ARB_GRANT_A;
                end else begin
                    state_d = ARB_IDLE;
                end
            end else begin
                prio_d = SEL_A;
                if (a_valid) begin
                    state_d = ARB_GRANT_A;
                end else if (b_valid) begin
                    state_d = ARB_GRANT_B;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
        end

        if (overrun) begin
            ovr_d = 1'b1;
        end else if (err_clr) begin
            ovr_d = 1'b0;
        end

        if (state_d == ARB_GRANT_A) begin
            sel_d = SEL_A;
        end else if (state_d == ARB_GRANT_B) begin
            sel_d = SEL_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            prio_q  <= SEL_A;
            sel_q   <= SEL_A;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            sel_q   <= sel_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_data    = (sel_q == SEL_B) ? b_data : a_data;
    assign sel         = sel_q;
    assign busy        = (state_q != ARB_IDLE);
    assign overrun_err = ovr_q;

endmodule
